// File: rtl/golden_pkg.sv
// Shared types and encodings for the golden_core memory subsystem.
// NOP/HALT encodings mirror architecture.vh.
package golden_pkg;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RUN,
        ST_HALTED
    } sys_state_t;

    localparam int INSTRUCTION_SIZE = 32;
    localparam int DATA_SIZE        = 32;
    localparam int ADDRESS_SIZE     = 16;

    localparam logic [31:0] NOP_INST  = 32'h0000_0000;
    localparam logic [31:0] HALT_INST = 32'hFC00_0000;

endpackage

// File: rtl/golden_sp_ram.sv
// Single write port, asynchronous read port RAM; contents are never reset.
// Read latency 0, write on posedge; no backpressure.
module golden_sp_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/golden_mem_subsystem.sv
// Program ROM + data RAM for golden_core with LOAD -> RUN -> HALTED sequencing.
// Fetch/data reads are 0-latency; loader is accepted only while load_ready (LOAD state).
module golden_mem_subsystem
    import golden_pkg::*;
#(
    parameter int INSTR_WIDTH = INSTRUCTION_SIZE,
    parameter int DATA_WIDTH  = DATA_SIZE,
    parameter int ADDR_WIDTH  = ADDRESS_SIZE,
    parameter int IMEM_DEPTH  = 256,
    parameter int DMEM_DEPTH  = 256,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic                   load_dmem,
    input  logic [ADDR_WIDTH-1:0]  load_addr,
    input  logic [DATA_WIDTH-1:0]  load_data,
    input  logic                   load_done,
    output logic                   core_reset,
    input  logic [ADDR_WIDTH-1:0]  pc,
    output logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   read,
    input  logic                   write,
    input  logic [ADDR_WIDTH-1:0]  address,
    input  logic [DATA_WIDTH-1:0]  data_out,
    output logic [DATA_WIDTH-1:0]  data_in,
    output logic                   halted,
    output logic                   mem_error,
    output logic [CNT_WIDTH-1:0]   cycle_count,
    output logic [CNT_WIDTH-1:0]   retired_count
);

    localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]  IMEM_LIM = (ADDR_WIDTH+1)'(IMEM_DEPTH);
    localparam logic [ADDR_WIDTH:0]  DMEM_LIM = (ADDR_WIDTH+1)'(DMEM_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [INSTR_WIDTH-1:0] NOP_I  = INSTR_WIDTH'(NOP_INST);
    localparam logic [INSTR_WIDTH-1:0] HALT_I = INSTR_WIDTH'(HALT_INST);

    sys_state_t            state;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  run_first;

    logic in_load, in_run, in_halt;
    logic pc_ok, ld_ok, ld_fire, addr_ok;
    logic core_bad, core_wr, core_rd;
    logic imem_we, dmem_we;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic [DATA_WIDTH-1:0]  dmem_rdata;

    assign in_load = (state == ST_LOAD);
    assign in_run  = (state == ST_RUN);
    assign in_halt = (state == ST_HALTED);

    assign pc_ok   = ({1'b0, pc} < IMEM_LIM);
    assign addr_ok = ({1'b0, address} < DMEM_LIM);
    assign ld_ok   = load_dmem ? ({1'b0, load_addr} < DMEM_LIM) : ({1'b0, load_addr} < IMEM_LIM);
    assign ld_fire = load_valid & load_ready;

    // Core data port is live once the core is out of reset; stores stop at HALT.
    assign core_bad = !in_load & (read | write) & ((read & write) | !addr_ok);
    assign core_wr  = in_run & write & !read & addr_ok;
    assign core_rd  = !in_load & read & !write & addr_ok;

    assign imem_we = ld_fire & ld_ok & !load_dmem;
    assign dmem_we = (ld_fire & ld_ok & load_dmem) | core_wr;

    golden_sp_ram #(.WIDTH(INSTR_WIDTH), .DEPTH(IMEM_DEPTH), .AW(IAW)) u_imem (
        .clock (clock),
        .we    (imem_we),
        .waddr (load_addr[IAW-1:0]),
        .wdata (load_data[INSTR_WIDTH-1:0]),
        .raddr (pc[IAW-1:0]),
        .rdata (imem_rdata)
    );

    golden_sp_ram #(.WIDTH(DATA_WIDTH), .DEPTH(DMEM_DEPTH), .AW(DAW)) u_dmem (
        .clock (clock),
        .we    (dmem_we),
        .waddr (in_load ? load_addr[DAW-1:0] : address[DAW-1:0]),
        .wdata (in_load ? load_data : data_out),
        .raddr (address[DAW-1:0]),
        .rdata (dmem_rdata)
    );

    always_comb begin
        instruction = NOP_I;
        if (in_halt) begin
            instruction = HALT_I;
        end else if (in_run && pc_ok) begin
            instruction = imem_rdata;
        end
    end

    assign data_in = core_rd ? dmem_rdata : '0;

    // run_first makes the first RUN cycle count as a retirement of the word at pc.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_LOAD;
            core_reset    <= 1'b1;
            load_ready    <= 1'b1;
            halted        <= 1'b0;
            mem_error     <= 1'b0;
            cycle_count   <= '0;
            retired_count <= '0;
            pc_q          <= '0;
            run_first     <= 1'b1;
        end else begin
            if ((ld_fire && !ld_ok) || (in_run && !pc_ok) || core_bad) begin
                mem_error <= 1'b1;
            end
            case (state)
                ST_LOAD: begin
                    if (load_done) begin
                        state      <= ST_RUN;
                        core_reset <= 1'b0;
                        load_ready <= 1'b0;
                    end
                end
                ST_RUN: begin
                    pc_q      <= pc;
                    run_first <= 1'b0;
                    if (cycle_count != CNT_MAX) begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                    if ((run_first || pc != pc_q) && retired_count != CNT_MAX) begin
                        retired_count <= retired_count + 1'b1;
                    end
                    if (instruction == HALT_I) begin
                        state  <= ST_HALTED;
                        halted <= 1'b1;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_golden_mem_subsystem.sv
// Bench for golden_mem_subsystem: directed program runs plus random core traffic
// compared every cycle against an array-based model of the memory subsystem.
module tb_golden_mem_subsystem;
    import golden_pkg::*;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int DEP  = 256;

    logic        clock, reset;
    logic        load_valid, load_ready, load_dmem, load_done;
    logic [15:0] load_addr;
    logic [31:0] load_data;
    logic        core_reset;
    logic [15:0] pc;
    logic [31:0] instruction;
    logic        read, write;
    logic [15:0] address;
    logic [31:0] data_out, data_in;
    logic        halted, mem_error;
    logic [CW-1:0] cycle_count, retired_count;

    golden_mem_subsystem #(
        .INSTR_WIDTH(32), .DATA_WIDTH(32), .ADDR_WIDTH(16),
        .IMEM_DEPTH(DEP), .DMEM_DEPTH(DEP), .CNT_WIDTH(CW)
    ) dut (
        .clock(clock), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready), .load_dmem(load_dmem),
        .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
        .core_reset(core_reset), .pc(pc), .instruction(instruction),
        .read(read), .write(write), .address(address),
        .data_out(data_out), .data_in(data_in),
        .halted(halted), .mem_error(mem_error),
        .cycle_count(cycle_count), .retired_count(retired_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 = loading, 1 = running, 2 = halted.
    logic [31:0] m_imem [DEP];
    logic [31:0] m_dmem [DEP];
    int m_phase, m_cyc, m_ret, m_last_pc;
    bit m_err;
    logic [31:0] prog [9];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] e_instr, e_din;
        int a, p;
        a = int'(address);
        p = int'(pc);
        if (m_phase == 2)                 e_instr = HALT_INST;
        else if (m_phase == 1 && p < DEP) e_instr = m_imem[p];
        else                              e_instr = NOP_INST;
        e_din = (m_phase != 0 && read && !write && a < DEP) ? m_dmem[a] : 32'h0;
        chk("core_reset", {31'b0, core_reset}, {31'b0, m_phase == 0});
        chk("load_ready", {31'b0, load_ready}, {31'b0, m_phase == 0});
        chk("halted", {31'b0, halted}, {31'b0, m_phase == 2});
        chk("mem_error", {31'b0, mem_error}, {31'b0, m_err});
        chk("cycle_count", 32'(cycle_count), 32'(m_cyc));
        chk("retired_count", 32'(retired_count), 32'(m_ret));
        chk("instruction", instruction, e_instr);
        chk("data_in", data_in, e_din);
    endtask

    task automatic data_access(input bit may_store);
        int a;
        a = int'(address);
        if (read || write) begin
            if ((read && write) || a >= DEP) m_err = 1;
            else if (write && may_store)     m_dmem[a] = data_out;
        end
    endtask

    task automatic model_step();
        int p, a;
        int next_phase;
        p = int'(pc);
        a = int'(load_addr);
        if (reset) begin
            m_phase = 0; m_err = 0; m_cyc = 0; m_ret = 0; m_last_pc = -1;
            return;
        end
        next_phase = m_phase;
        if (m_phase == 0) begin
            if (load_valid) begin
                if (a >= DEP)       m_err = 1;
                else if (load_dmem) m_dmem[a] = load_data;
                else                m_imem[a] = load_data;
            end
            if (load_done) next_phase = 1;
        end else if (m_phase == 1) begin
            if (m_cyc < CMAX) m_cyc++;
            if (p != m_last_pc && m_ret < CMAX) m_ret++;
            m_last_pc = p;
            if (p >= DEP)                    m_err = 1;
            else if (m_imem[p] == HALT_INST) next_phase = 2;
            data_access(1'b1);
        end else begin
            data_access(1'b0);
        end
        m_phase = next_phase;
    endtask

    task automatic cycle();
        @(negedge clock);
        check_all();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic load_word(input bit to_dmem, input int addr, input logic [31:0] d);
        load_valid = 1'b1; load_dmem = to_dmem; load_addr = 16'(addr); load_data = d;
        cycle();
        load_valid = 1'b0;
    endtask

    task automatic start_run();
        load_done = 1'b1;
        cycle();
        load_done = 1'b0;
        chk("core_reset_fall", {31'b0, core_reset}, 32'h0);
    endtask

    task automatic run_pc(input int p);
        pc = 16'(p);
        cycle();
    endtask

    initial begin
        logic [31:0] w;
        reset = 1'b1; load_valid = 1'b0; load_dmem = 1'b0; load_addr = '0; load_data = '0;
        load_done = 1'b0; pc = '0; read = 1'b0; write = 1'b0; address = '0; data_out = '0;
        m_phase = 0; m_err = 0; m_cyc = 0; m_ret = 0; m_last_pc = -1;
        for (int i = 0; i < 8; i++) prog[i] = 32'h1000_0000 | (32'(i) << 21) | 32'(i * 3 + 1);
        prog[8] = HALT_INST;

        @(posedge clock); model_step(); #1;
        cycle();
        reset = 1'b0;

        // Out-of-range load is dropped and flags an error; reset clears the flag.
        load_word(1'b0, 16'h100, 32'h1234_5678);
        chk("load_oob_err", {31'b0, mem_error}, 32'h1);
        reset = 1'b1; cycle(); reset = 1'b0;
        chk("err_cleared", {31'b0, mem_error}, 32'h0);

        for (int i = 0; i < DEP; i++) begin
            w = $urandom;
            if (w == HALT_INST) w = w ^ 32'h1;
            load_word(1'b0, i, (i < 9) ? prog[i] : w);
            load_word(1'b1, i, (i == 8'h30) ? 32'hDEAD_BEEF : $urandom);
        end

        // Program 1: pc walks 0..8, loader poke at pc 3 must be ignored.
        start_run();
        for (int p = 0; p < 9; p++) begin
            if (p == 3) begin
                load_valid = 1'b1; load_dmem = 1'b0; load_addr = 16'd5; load_data = 32'hAAAA_5555;
            end
            run_pc(p);
            load_valid = 1'b0;
        end
        chk("halt_flag", {31'b0, halted}, 32'h1);
        chk("retired_at_halt", 32'(retired_count), 32'd9);
        chk("cycles_at_halt", 32'(cycle_count), 32'd9);
        write = 1'b1; address = 16'h40; data_out = 32'h0BAD_F00D; pc = 16'd9;
        cycle(); cycle();
        write = 1'b0;
        chk("frozen_retired", 32'(retired_count), 32'd9);
        chk("halt_instr", instruction, HALT_INST);

        // Program 2: data port directed checks.
        reset = 1'b1; cycle(); reset = 1'b0;
        start_run();
        read = 1'b1; address = 16'h30; pc = 16'd0; #2;
        chk("dmem_loaded", data_in, 32'hDEAD_BEEF);
        cycle();
        address = 16'h40; pc = 16'd1; #2;
        chk("halted_store_blocked", data_in, m_dmem[8'h40]);
        cycle();
        address = 16'h1C; pc = 16'd2; #2;
        w = data_in;
        chk("old_before_store", w, m_dmem[8'h1C]);
        cycle();
        read = 1'b0; write = 1'b1; data_out = 32'h1FFF_FFFC; pc = 16'd3; #2;
        chk("store_no_read", data_in, 32'h0);
        cycle();
        write = 1'b0; read = 1'b1; pc = 16'd5; #2;
        chk("read_after_store", data_in, 32'h1FFF_FFFC);
        chk("imem_not_loaded_in_run", instruction, prog[5]);
        cycle();
        read = 1'b0;
        chk("no_err_yet", {31'b0, mem_error}, 32'h0);

        // Random core traffic; long enough to saturate the cycle counter.
        for (int n = 0; n < 60; n++) begin
            int p;
            p = $urandom_range(0, 270);
            if (p == 8) p = 9;
            pc = 16'(p);
            read = ($urandom_range(0, 3) == 0);
            write = ($urandom_range(0, 3) == 0);
            address = 16'($urandom_range(0, 265));
            data_out = $urandom;
            cycle();
        end
        read = 1'b0; write = 1'b0;
        chk("cycle_saturated", 32'(cycle_count), 32'(CMAX));
        pc = 16'h100; #2;
        chk("oob_fetch_nop", instruction, NOP_INST);
        cycle();
        pc = 16'd1; cycle();
        chk("err_sticky", {31'b0, mem_error}, 32'h1);

        // Reset mid-run after 5 cycles, then rerun to the same HALT.
        reset = 1'b1; cycle(); reset = 1'b0;
        start_run();
        for (int p = 0; p < 5; p++) run_pc(p);
        reset = 1'b1; cycle(); reset = 1'b0;
        chk("midrun_core_reset", {31'b0, core_reset}, 32'h1);
        chk("midrun_cycles", 32'(cycle_count), 32'h0);
        chk("midrun_retired", 32'(retired_count), 32'h0);
        start_run();
        for (int p = 0; p < 9; p++) run_pc(p);
        chk("rerun_halted", {31'b0, halted}, 32'h1);
        chk("rerun_retired", 32'(retired_count), 32'd9);
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
